regfile_dump_reader: RTL

Sequential read-side master for the 32x32 register file. On a start pulse it walks the read address port (A1/RD1) over a programmable register range. It captures each register value and streams it out as (index, data) words over a valid/ready handshake. Used by the monocycle and multicycle testbenches and debug logic to dump architectural state in hardware, in place of simulation-only prints.

---
 rtl/regfile_dump_reader_if.sv | 26 ++
 rtl/regfile_dump_reader.sv | 79 +++++++
 2 files changed

// File: rtl/regfile_dump_reader_if.sv
// regfile_dump_reader_if: control, register-file read port and word-stream handshake of the dump reader
interface regfile_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] first_reg;
  logic [ADDR_W-1:0] last_reg;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_idx;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   out_count;
  modport master (
    input  start, first_reg, last_reg, rd_data, out_ready,
    output rd_addr, out_valid, out_idx, out_data, busy, done, out_count
  );
  modport slave (
    output start, first_reg, last_reg, rd_data, out_ready,
    input  rd_addr, out_valid, out_idx, out_data, busy, done, out_count
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a register-file range on start and streams (index, data) words over valid/ready
module regfile_dump_reader #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int SKIP_ZERO = 0
) (
  input logic                   clk,
  input logic                   reset,
  regfile_dump_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              done_q;
  logic [ADDR_W:0]   count_q;
  logic              skip;
  logic              at_last;
  assign skip          = (SKIP_ZERO != 0) && (bus.rd_data == '0);
  assign at_last       = cur_q == last_q;
  assign bus.rd_addr   = state_q == READ ? cur_q : '0;
  assign bus.out_valid = valid_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_data  = data_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = done_q;
  assign bus.out_count = count_q;
  // cur wraps naturally at 2**ADDR_W, so first_reg > last_reg walks through 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          cur_q   <= bus.first_reg;
          last_q  <= bus.last_reg;
          count_q <= '0;
          state_q <= READ;
        end
        READ: begin
          idx_q  <= cur_q;
          data_q <= bus.rd_data;
          if (!skip) begin
            valid_q <= 1'b1;
            state_q <= SEND;
          end else if (at_last) begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            cur_q <= cur_q + 1'b1;
          end
        end
        SEND: if (bus.out_ready) begin
          valid_q <= 1'b0;
          count_q <= count_q + 1'b1;
          if (at_last) begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            cur_q   <= cur_q + 1'b1;
            state_q <= READ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
